// File: rtl/roulette_pkg.sv
// Shared roulette definitions: bet-entry state encoding, stake defaults and
// the payout multiplier table used by both bet entry and the money manager.
package roulette_pkg;

  typedef enum logic [1:0] {
    BET_IDLE   = 2'd0,
    BET_AMOUNT = 2'd1,
    BET_PICK   = 2'd2,
    BET_READY  = 2'd3
  } bet_state_e;

  localparam int          DEF_NUM_SLOTS   = 8;
  localparam int          DEF_MAX_PICKS   = 4;
  localparam logic [15:0] DEF_MIN_BET     = 16'd10;
  localparam logic [15:0] DEF_STEP        = 16'd10;
  localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd500_000_000;

  // Payout multiplier is NUM_SLOTS / pick count, truncated; zero picks pays nothing.
  function automatic logic [3:0] payout_mult(input logic [2:0] pickCount);
    logic [3:0] mult;
    case (pickCount)
      3'd1:    mult = 4'd8;
      3'd2:    mult = 4'd4;
      3'd3:    mult = 4'd2;
      3'd4:    mult = 4'd2;
      default: mult = 4'd0;
    endcase
    return mult;
  endfunction

endpackage

// File: rtl/bet_timeout_timer.sv
// Inactivity timer for bet entry. Only built when BET_ENTRY_TIMEOUT_EN is
// defined; counts enabled cycles, restarts on clear, and flags expiry on the
// cycle the count reaches LIMIT-1.
`ifdef BET_ENTRY_TIMEOUT_EN
module bet_timeout_timer #(
  parameter logic [31:0] LIMIT = 32'd500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic countEn_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Expiry is flagged while the last counted cycle is in progress.
  always_comb begin
    expire_o = countEn_i && !clear_i && (count_q == LIMIT - 32'd1);
  end

  // Count restarts whenever the timer is idle, cleared or has just expired.
  always_comb begin
    count_d = count_q + 32'd1;
    if (!countEn_i || clear_i || expire_o) begin
      count_d = 32'd0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/bet_entry.sv
// Player bet-entry stage: collects a stake and up to MAX_PICKS wheel numbers,
// then offers the bet to the game FSM with a ready/ack handshake.
// Optional inactivity abort is enabled by defining BET_ENTRY_TIMEOUT_EN.
module bet_entry
  import roulette_pkg::*;
#(
  parameter int          NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter int          MAX_PICKS   = DEF_MAX_PICKS,
  parameter logic [15:0] MIN_BET     = DEF_MIN_BET,
  parameter logic [15:0] STEP        = DEF_STEP,
  parameter logic [31:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_req,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_pick,
  input  logic                         btn_confirm,
  input  logic                         btn_clear,
  input  logic [$clog2(NUM_SLOTS)-1:0] sw_number,
  input  logic [15:0]                  current_money,
  input  logic                         bet_ack,
  output logic [15:0]                  bet_amount,
  output logic [2:0]                   bet_count,
  output logic [NUM_SLOTS-1:0]         bet_mask,
  output logic                         bet_ready,
  output logic                         busy,
  output logic                         err_pulse,
  output logic                         abort_pulse
);

  localparam logic [2:0] MaxCount = 3'(MAX_PICKS);

  bet_state_e state_q, state_d;

  logic [15:0]          amount_q, amount_d;
  logic [2:0]           count_q, count_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 abort_q, abort_d;

  logic        actClear, actConfirm, actPick, actUp, actDown;
  logic        anyButton;
  logic        pickBitSet;
  logic [15:0] downFloor;
  logic [16:0] upSum;
  logic [16:0] downLimit;
  logic        timeoutExpire;

  // Priority decode: clear > confirm > pick > up > down, only one acts.
  always_comb begin
    actClear   = btn_clear;
    actConfirm = btn_confirm & ~btn_clear;
    actPick    = btn_pick & ~btn_confirm & ~btn_clear;
    actUp      = btn_up & ~btn_pick & ~btn_confirm & ~btn_clear;
    actDown    = btn_down & ~btn_up & ~btn_pick & ~btn_confirm & ~btn_clear;
    anyButton  = btn_clear | btn_confirm | btn_pick | btn_up | btn_down;
    pickBitSet = mask_q[sw_number];
    downFloor  = (current_money < MIN_BET) ? current_money : MIN_BET;
    upSum      = {1'b0, amount_q} + {1'b0, STEP};
    downLimit  = {1'b0, downFloor} + {1'b0, STEP};
  end

`ifdef BET_ENTRY_TIMEOUT_EN
  logic timerEn;

  // The timer only runs while the player is actively entering a bet.
  always_comb begin
    timerEn = (state_q == BET_AMOUNT) || (state_q == BET_PICK);
  end

  bet_timeout_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .countEn_i(timerEn),
    .clear_i  (anyButton),
    .expire_o (timeoutExpire)
  );
`else
  logic unused_timeout_cfg;

  // Without the timeout feature entry waits forever and never aborts.
  always_comb begin
    timeoutExpire      = 1'b0;
    unused_timeout_cfg = ^TIMEOUT_CYC ^ anyButton;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BET_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a timeout overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BET_IDLE: begin
        if (start_req) state_d = BET_AMOUNT;
      end
      BET_AMOUNT: begin
        if (actConfirm && (amount_q != 16'd0)) state_d = BET_PICK;
      end
      BET_PICK: begin
        if (actClear) begin
          state_d = BET_AMOUNT;
        end else if (actConfirm && (count_q != 3'd0)) begin
          state_d = BET_READY;
        end
      end
      BET_READY: begin
        if (bet_ack) state_d = BET_IDLE;
      end
      default: state_d = BET_IDLE;
    endcase
    if (timeoutExpire) state_d = BET_IDLE;
  end

  // Output/datapath logic: next values for every registered output.
  always_comb begin
    amount_d = amount_q;
    count_d  = count_q;
    mask_d   = mask_q;
    err_d    = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      BET_IDLE: begin
        if (start_req) begin
          amount_d = downFloor;
          count_d  = 3'd0;
          mask_d   = '0;
        end
      end
      BET_AMOUNT: begin
        if (actConfirm) begin
          if (amount_q == 16'd0) err_d = 1'b1;
        end else if (actUp) begin
          amount_d = (upSum > {1'b0, current_money}) ? current_money : upSum[15:0];
        end else if (actDown) begin
          if ({1'b0, amount_q} >= downLimit) begin
            amount_d = amount_q - STEP;
          end else if (amount_q > downFloor) begin
            amount_d = downFloor;
          end
        end
        if (amount_d > current_money) amount_d = current_money;
      end
      BET_PICK: begin
        if (actClear) begin
          mask_d  = '0;
          count_d = 3'd0;
        end else if (actConfirm) begin
          if (count_q == 3'd0) err_d = 1'b1;
        end else if (actPick) begin
          if (pickBitSet) begin
            mask_d[sw_number] = 1'b0;
            count_d           = count_q - 3'd1;
          end else if (count_q == MaxCount) begin
            err_d = 1'b1;
          end else begin
            mask_d[sw_number] = 1'b1;
            count_d           = count_q + 3'd1;
          end
        end
        if (amount_d > current_money) amount_d = current_money;
      end
      default: begin
      end
    endcase
    if (timeoutExpire) begin
      amount_d = 16'd0;
      count_d  = 3'd0;
      mask_d   = '0;
      err_d    = 1'b0;
      abort_d  = 1'b1;
    end
    ready_d = (state_d == BET_READY);
    busy_d  = (state_d != BET_IDLE);
  end

  // Output registers; reset discards any partially entered bet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amount_q <= 16'd0;
      count_q  <= 3'd0;
      mask_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      amount_q <= amount_d;
      count_q  <= count_d;
      mask_q   <= mask_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

  assign bet_amount  = amount_q;
  assign bet_count   = count_q;
  assign bet_mask    = mask_q;
  assign bet_ready   = ready_q;
  assign busy        = busy_q;
  assign err_pulse   = err_q;
  assign abort_pulse = abort_q;

endmodule

// File: tb/tb_bet_entry.sv
// Directed testbench for bet_entry. The DUT is built with TIMEOUT_CYC=20 so
// the abort path is short when BET_ENTRY_TIMEOUT_EN is defined.
module tb_bet_entry;

  localparam logic [6:0] B_NONE    = 7'b0000000;
  localparam logic [6:0] B_START   = 7'b1000000;
  localparam logic [6:0] B_UP      = 7'b0100000;
  localparam logic [6:0] B_DOWN    = 7'b0010000;
  localparam logic [6:0] B_PICK    = 7'b0001000;
  localparam logic [6:0] B_CONFIRM = 7'b0000100;
  localparam logic [6:0] B_CLEAR   = 7'b0000010;
  localparam logic [6:0] B_ACK     = 7'b0000001;

  logic        clk;
  logic        rst;
  logic        startReq, btnUp, btnDown, btnPick, btnConfirm, btnClear, betAck;
  logic [2:0]  swNumber;
  logic [15:0] currentMoney;
  logic [15:0] betAmount;
  logic [2:0]  betCount;
  logic [7:0]  betMask;
  logic        betReady, busy, errPulse, abortPulse;

  int testsRun;
  int testsFailed;
  int holdBad;

  bet_entry #(
    .TIMEOUT_CYC(32'd20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_req    (startReq),
    .btn_up       (btnUp),
    .btn_down     (btnDown),
    .btn_pick     (btnPick),
    .btn_confirm  (btnConfirm),
    .btn_clear    (btnClear),
    .sw_number    (swNumber),
    .current_money(currentMoney),
    .bet_ack      (betAck),
    .bet_amount   (betAmount),
    .bet_count    (betCount),
    .bet_mask     (betMask),
    .bet_ready    (betReady),
    .busy         (busy),
    .err_pulse    (errPulse),
    .abort_pulse  (abortPulse)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one button vector for exactly one cycle, returning at the
  // following falling edge when the result is visible.
  task automatic applyStimulus(input logic [6:0] v);
    @(negedge clk);
    {startReq, btnUp, btnDown, btnPick, btnConfirm, btnClear, betAck} = v;
    @(negedge clk);
    {startReq, btnUp, btnDown, btnPick, btnConfirm, btnClear, betAck} = B_NONE;
  endtask

  // Selects a wheel number and pulses btn_pick.
  task automatic pickNumber(input logic [2:0] n);
    swNumber = n;
    applyStimulus(B_PICK);
  endtask

  // Main directed sequence.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    {startReq, btnUp, btnDown, btnPick, btnConfirm, btnClear, betAck} = B_NONE;
    swNumber     = 3'd0;
    currentMoney = 16'd100;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset amount", 32'(betAmount), 32'd0);
    checkOutput("reset mask/count", {21'd0, betMask, betCount}, 32'd0);
    checkOutput("reset flags", {28'd0, betReady, busy, errPulse, abortPulse}, 32'd0);
    rst = 1'b1;

    // Amount entry with a balance of 100.
    applyStimulus(B_START);
    checkOutput("start amount", 32'(betAmount), 32'd10);
    checkOutput("start busy", 32'(busy), 32'd1);
    repeat (3) applyStimulus(B_UP);
    checkOutput("up x3", 32'(betAmount), 32'd40);
    repeat (5) applyStimulus(B_DOWN);
    checkOutput("down sat min", 32'(betAmount), 32'd10);
    repeat (12) applyStimulus(B_UP);
    checkOutput("up sat money", 32'(betAmount), 32'd100);
    applyStimulus(B_START);
    checkOutput("start ignored", 32'(betAmount), 32'd100);

    // Pick limit and toggle.
    applyStimulus(B_CONFIRM);
    checkOutput("to pick err", 32'(errPulse), 32'd0);
    pickNumber(3'd1);
    pickNumber(3'd3);
    pickNumber(3'd5);
    pickNumber(3'd7);
    checkOutput("four picks mask", 32'(betMask), 32'hAA);
    checkOutput("four picks count", 32'(betCount), 32'd4);
    pickNumber(3'd0);
    checkOutput("fifth pick err", 32'(errPulse), 32'd1);
    checkOutput("fifth pick mask", 32'(betMask), 32'hAA);
    applyStimulus(B_NONE);
    checkOutput("err one cycle", 32'(errPulse), 32'd0);
    pickNumber(3'd3);
    checkOutput("untoggle mask", 32'(betMask), 32'hA2);
    checkOutput("untoggle count", 32'(betCount), 32'd3);

    // Clear beats confirm; the block must return to amount entry.
    applyStimulus(B_CLEAR | B_CONFIRM);
    checkOutput("clear wins mask", {21'd0, betMask, betCount}, 32'd0);
    checkOutput("clear wins ready", 32'(betReady), 32'd0);
    checkOutput("clear keeps amount", 32'(betAmount), 32'd100);
    applyStimulus(B_DOWN);
    checkOutput("back in amount", 32'(betAmount), 32'd90);

    // Empty confirm in PICK, then clear.
    applyStimulus(B_CONFIRM);
    applyStimulus(B_CONFIRM);
    checkOutput("empty confirm err", 32'(errPulse), 32'd1);
    checkOutput("empty confirm ready", 32'(betReady), 32'd0);
    pickNumber(3'd0);
    checkOutput("still in pick", {21'd0, betMask, betCount}, {21'd0, 8'h01, 3'd1});
    applyStimulus(B_CLEAR);
    checkOutput("clear mask", 32'(betMask), 32'h00);
    checkOutput("clear amount kept", 32'(betAmount), 32'd90);

    // Handshake: ready rises after confirm and holds until ack.
    applyStimulus(B_CONFIRM);
    pickNumber(3'd0);
    applyStimulus(B_CONFIRM);
    checkOutput("ready rise", 32'(betReady), 32'd1);
    holdBad = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? B_UP : B_CLEAR);
      if (betReady !== 1'b1 || betAmount !== 16'd90 || betMask !== 8'h01) holdBad++;
    end
    checkOutput("ready hold 10", 32'(holdBad), 32'd0);
    applyStimulus(B_ACK);
    checkOutput("ack ready", {30'd0, betReady, busy}, 32'd0);
    checkOutput("ack retain", {5'd0, betAmount, betMask, betCount},
                {5'd0, 16'd90, 8'h01, 3'd1});
    applyStimulus(B_ACK);
    checkOutput("ack in idle", {30'd0, betReady, busy}, 32'd0);

    // Low balance, clamping and zero-amount confirm.
    currentMoney = 16'd5;
    applyStimulus(B_START);
    checkOutput("low start", 32'(betAmount), 32'd5);
    checkOutput("low start mask", {21'd0, betMask, betCount}, 32'd0);
    applyStimulus(B_DOWN);
    checkOutput("low down", 32'(betAmount), 32'd5);
    currentMoney = 16'd100;
    applyStimulus(B_UP);
    checkOutput("up from low", 32'(betAmount), 32'd15);
    currentMoney = 16'd12;
    applyStimulus(B_NONE);
    checkOutput("clamp to money", 32'(betAmount), 32'd12);
    currentMoney = 16'd0;
    applyStimulus(B_NONE);
    applyStimulus(B_CONFIRM);
    checkOutput("zero confirm err", 32'(errPulse), 32'd1);
    currentMoney = 16'd100;
    applyStimulus(B_UP);
    checkOutput("zero stayed amount", 32'(betAmount), 32'd10);

    // Asynchronous reset in the middle of PICK.
    applyStimulus(B_CONFIRM);
    pickNumber(3'd2);
    checkOutput("pre reset mask", 32'(betMask), 32'h04);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset data", {5'd0, betAmount, betMask, betCount}, 32'd0);
    checkOutput("async reset flags", {28'd0, betReady, busy, errPulse, abortPulse}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(B_CONFIRM);
    checkOutput("no ready after reset", {30'd0, betReady, busy}, 32'd0);

    // Inactivity behaviour in AMOUNT.
    applyStimulus(B_START);
`ifdef BET_ENTRY_TIMEOUT_EN
    holdBad = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (abortPulse !== 1'b0 || busy !== 1'b1) holdBad++;
    end
    checkOutput("no early abort", 32'(holdBad), 32'd0);
    @(negedge clk);
    checkOutput("abort pulse", 32'(abortPulse), 32'd1);
    checkOutput("abort idle", {5'd0, betAmount, betMask, betCount, busy}, 32'd0);
    @(negedge clk);
    checkOutput("abort one cycle", 32'(abortPulse), 32'd0);
`else
    repeat (25) @(negedge clk);
    checkOutput("no abort", 32'(abortPulse), 32'd0);
    checkOutput("waits forever", {15'd0, busy, betAmount}, {15'd0, 1'b1, 16'd10});
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bet_entry.md
# bet_entry

Player bet-entry stage that sits directly upstream of the money manager and the hit checker. Once the game FSM opens a round, it collects a bet amount and up to four wheel numbers from debounced button pulses. It validates the amount against the live balance and presents the result with a ready/ack handshake. Its `bet_amount` and `bet_count` outputs feed the money manager's payout logic; `bet_mask` feeds the hit checker.

## Interface
- `NUM_SLOTS`, 8: wheel positions; `bet_mask` width. Payout multiplier is 8/count.
- `MAX_PICKS`, 4: maximum numbers per bet.
- `MIN_BET`, 16'd10: minimum stake.
- `STEP`, 16'd10: amount increment/decrement.
- `TIMEOUT_CYC`, 32'd500_000_000: inactivity limit. Used only with the macro.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `start_req` in 1: FSM pulse; opens entry.
- `btn_up` in 1: pulse; amount += STEP.
- `btn_down` in 1: pulse; amount -= STEP.
- `btn_pick` in 1: pulse; toggle number `sw_number`.
- `btn_confirm` in 1: pulse; advance.
- `btn_clear` in 1: pulse; back to amount entry.
- `sw_number` in 3: number selected by switches.
- `current_money` in 16: live balance from money manager.
- `bet_ack` in 1: FSM consumed the bet.
- `bet_amount` out 16: stake.
- `bet_count` out 3: number of picks, 0..4.
- `bet_mask` out NUM_SLOTS: one-hot-per-number pick set.
- `bet_ready` out 1: bet valid; held until ack.
- `busy` out 1: state is not IDLE.
- `err_pulse` out 1: one-cycle illegal-action strobe.
- `abort_pulse` out 1: one-cycle timeout strobe. Tied 0 without the macro.

## Operation
- States: IDLE, AMOUNT, PICK, READY. Encoding lives in the package.
- IDLE:
  - `start_req` leads to AMOUNT.
  - `bet_amount` loads min(MIN_BET, `current_money`).
  - `bet_mask`/`bet_count` clear.
- AMOUNT:
  - `btn_up` adds STEP, saturating at `current_money`.
  - `btn_down` subtracts STEP, saturating at MIN_BET. If `current_money` < MIN_BET, it saturates at `current_money`.
  - `btn_confirm` goes to PICK if amount ≥ 1; otherwise it raises `err_pulse` and stays in AMOUNT.
- PICK:
  - `btn_pick` toggles bit `sw_number`.
  - Setting a bit when count = MAX_PICKS is refused with `err_pulse`.
  - `btn_confirm` with count ≥ 1 goes to READY; with count 0 it raises `err_pulse`.
  - `btn_clear` clears the mask and returns to AMOUNT, keeping the amount.
- READY:
  - `bet_ready` = 1 and buttons are ignored.
  - `bet_ack` returns to IDLE. `bet_amount`/`bet_count`/`bet_mask` hold their values until the next `start_req`, so the money manager's later update reads stable values.
- Button priority when several pulse in one cycle: clear > confirm > pick > up > down. Only the highest is acted on.
- `start_req` outside IDLE is ignored.
- `bet_count` always equals popcount(`bet_mask`). It is kept as a registered counter updated alongside the toggle, never recomputed combinationally on the output.
- Arithmetic is 17-bit internally so that up-saturation cannot wrap; the result is truncated to 16 bits.
- If `current_money` drops below `bet_amount` during AMOUNT or PICK, `bet_amount` clamps to `current_money` on the next cycle.

## Timing
- Reset (`rst`=0), asynchronous:
  - state IDLE;
  - `bet_amount`=0, `bet_count`=0, `bet_mask`=0;
  - `bet_ready`, `busy`, `err_pulse`, `abort_pulse` all 0.
- All outputs are registered.
- Each action takes effect on the first `clk` edge that samples the pulse, so the new value is visible the next cycle.
- `bet_ready` rises the cycle after the accepted confirm. It falls the cycle after `bet_ack` is sampled high.
- `bet_ack` outside READY is ignored.
- Reset asserted mid-entry discards the bet; no partial `bet_ready` is produced.
- `err_pulse` and `abort_pulse` are exactly one cycle wide.

## Configuration
- `BET_ENTRY_TIMEOUT_EN` defined:
  - An inactivity counter runs in AMOUNT and PICK and is reset by any button pulse.
  - At TIMEOUT_CYC−1 the block returns to IDLE, clears `bet_amount`/`bet_count`/`bet_mask`, and pulses `abort_pulse` for one cycle.
- `BET_ENTRY_TIMEOUT_EN` undefined:
  - There is no counter; entry waits indefinitely.
  - `abort_pulse` is constant 0.

## Structure
- Shared package `roulette_pkg` holds:
  - the state encoding `BET_IDLE/BET_AMOUNT/BET_PICK/BET_READY`;
  - the MIN_BET/STEP/MAX_PICKS defaults;
  - the payout multiplier table (also used by the money manager).
- One sub-module, `bet_timeout_timer` (count, clear, expire pulse), is instantiated only under `BET_ENTRY_TIMEOUT_EN`.

## Test plan
- Amount entry: `current_money`=100; `start_req`, 3× `btn_up`, 5× `btn_down` → amount 10, 40, then saturates at 10. 12× `btn_up` → amount saturates at 100.
- Low balance: `current_money`=5; `start_req` → `bet_amount`=5. `btn_down` → stays 5.
- Pick limit and toggle: pick 1, 3, 5, 7, then 0 → `bet_mask`=8'hAA, `bet_count`=4, `err_pulse` on the fifth pick. Pick 3 again → mask 8'hA2, count 3.
- Empty confirm and clear: confirm in PICK with count 0 → `err_pulse`, stays in PICK. `btn_clear` → AMOUNT, mask 0, amount unchanged.
- Handshake: confirm with mask 8'h01 → `bet_ready`=1 next cycle and holds 10 cycles without ack. `bet_ack` → IDLE, `bet_ready`=0, outputs retained. Simultaneous `btn_clear`+`btn_confirm` in PICK → clear wins.
- Reset and timeout: `rst` low mid-PICK → all outputs 0 asynchronously. With the macro and TIMEOUT_CYC=20, idle in AMOUNT → `abort_pulse` at cycle 20, state IDLE.
